// File: rtl/alu_seq_core.sv
// alu_seq_core: sequential 8-bit ALU with a shift-and-add multiplier.
// Single-cycle ops complete on the accepting edge. MUL takes eight
// shift-and-add steps. Each completion raises a one-cycle grab strobe
// for the downstream latch, and result/flags hold until the next completion.
module alu_seq_core (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] result,
  output logic [2:0]  flags,
  output logic        grab,
  output logic        busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_MUL = 3'b111;

  // Flag packing shared by both completion paths: {negative, carry, zero}.
  function automatic logic [2:0] pack_flags(input logic [15:0] res,
                                            input logic        neg,
                                            input logic        carry);
    pack_flags = {neg, carry, (res == 16'h0000)};
  endfunction

  state_t      state_r;
  logic [7:0]  mcand_r;
  logic [7:0]  mplier_r;
  logic [15:0] acc_r;
  logic [2:0]  count_r;

  logic [8:0]  sum_s;
  logic [8:0]  diff_s;
  logic [7:0]  alu_res_s;
  logic        alu_carry_s;
  logic [2:0]  alu_flags_s;
  logic [15:0] addend_s;
  logic [15:0] acc_next_s;
  logic [2:0]  mul_flags_s;

  // Single-cycle ALU datapath; operands come straight from the ports.
  always_comb begin
    sum_s       = {1'b0, a} + {1'b0, b};
    diff_s      = {1'b0, a} - {1'b0, b};
    alu_res_s   = 8'h00;
    alu_carry_s = 1'b0;
    case (op)
      OP_ADD: begin
        alu_res_s   = sum_s[7:0];
        alu_carry_s = sum_s[8];
      end
      OP_SUB: begin
        alu_res_s   = diff_s[7:0];
        alu_carry_s = diff_s[8];   // wraps negative exactly when a < b
      end
      OP_AND: begin
        alu_res_s   = a & b;
        alu_carry_s = 1'b0;
      end
      OP_OR: begin
        alu_res_s   = a | b;
        alu_carry_s = 1'b0;
      end
      OP_XOR: begin
        alu_res_s   = a ^ b;
        alu_carry_s = 1'b0;
      end
      OP_SHL: begin
        alu_res_s   = {a[6:0], 1'b0};
        alu_carry_s = a[7];
      end
      OP_SHR: begin
        alu_res_s   = {1'b0, a[7:1]};
        alu_carry_s = a[0];
      end
      default: begin
        alu_res_s   = 8'h00;
        alu_carry_s = 1'b0;
      end
    endcase
    alu_flags_s = pack_flags({8'h00, alu_res_s}, alu_res_s[7], alu_carry_s);
  end

  // One multiply step: add the shifted multiplicand when the current multiplier bit is set.
  always_comb begin
    if (mplier_r[count_r]) begin
      addend_s = {8'h00, mcand_r} << count_r;
    end else begin
      addend_s = 16'h0000;
    end
    acc_next_s  = acc_r + addend_s;
    mul_flags_s = pack_flags(acc_next_s, acc_next_s[15], (acc_next_s[15:8] != 8'h00));
  end

  // Control FSM with registered result, flags, grab and busy.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      result   <= 16'h0000;
      flags    <= 3'b000;
      mcand_r  <= 8'h00;
      mplier_r <= 8'h00;
      acc_r    <= 16'h0000;
      count_r  <= 3'd0;
      grab     <= 1'b0;
      busy     <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            if (op == OP_MUL) begin
              mcand_r  <= a;
              mplier_r <= b;
              acc_r    <= 16'h0000;
              count_r  <= 3'd0;
              state_r  <= ST_MUL;
              grab     <= 1'b0;
              busy     <= 1'b1;
            end else begin
              result  <= {8'h00, alu_res_s};
              flags   <= alu_flags_s;
              state_r <= ST_DONE;
              grab    <= 1'b1;
              busy    <= 1'b1;
            end
          end else begin
            grab <= 1'b0;
            busy <= 1'b0;
          end
        end
        ST_MUL: begin
          acc_r   <= acc_next_s;
          count_r <= count_r + 3'd1;
          busy    <= 1'b1;
          if (count_r == 3'd7) begin
            result  <= acc_next_s;
            flags   <= mul_flags_s;
            state_r <= ST_DONE;
            grab    <= 1'b1;
          end else begin
            grab <= 1'b0;
          end
        end
        ST_DONE: begin
          state_r <= ST_IDLE;
          grab    <= 1'b0;
          busy    <= 1'b0;
        end
        default: begin
          state_r <= ST_IDLE;
          grab    <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
